// File: rtl/la_ioanalog_arb.sv
// Round-robin arbiter for one shared analog pad with break-before-make and settle timing.
// Optional OWN-time limit with sticky err and requester masking: define LA_IOANALOG_ARB_TIMEOUT_EN.
module la_ioanalog_arb #(
  parameter int N         = 4,
  parameter int BREAKCYC  = 2,
  parameter int SETTLECYC = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         sw_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 err
);

  localparam int OW    = $clog2(N);
  localparam int MAXBS = (BREAKCYC > SETTLECYC) ? BREAKCYC : SETTLECYC;
  localparam int MAXC  = (MAXBS > TIMEOUT) ? MAXBS : TIMEOUT;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_SETTLE, S_OWN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [N-1:0]    r_sw_en;
  logic [N-1:0]    r_gnt;
  logic            r_busy;

  logic [N-1:0]    w_elig;
  logic [N-1:0]    w_owner_oh;
  logic [OW-1:0]   w_rot_idx [N];
  logic [OW-1:0]   w_win;
  logic [OW-1:0]   w_ptr_next;
  logic            w_req_own;

`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
  logic [N-1:0]    r_mask;
  logic            r_err;
  assign w_elig = req & ~r_mask;
  assign err    = r_err;
`else
  assign w_elig = req;
  assign err    = 1'b0;
`endif

  // Search order starts at r_ptr and wraps past N-1 back to 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_rot_idx[gi]  = (int'(r_ptr) + gi >= N) ? OW'(int'(r_ptr) + gi - N)
                                                   : OW'(int'(r_ptr) + gi);
    assign w_owner_oh[gi] = (r_owner == OW'(gi));
  end

  always_comb begin
    w_win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[w_rot_idx[i]]) w_win = w_rot_idx[i];
    end
  end

  assign w_ptr_next = (r_owner == OW'(N - 1)) ? '0 : r_owner + OW'(1);
  assign w_req_own  = req[r_owner];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_sw_en <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
      r_mask  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
      // A masked requester becomes eligible again once it has been seen low.
      r_mask <= r_mask & req;
`endif
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_owner <= w_win;
            r_cnt   <= CW'(BREAKCYC - 1);
            r_busy  <= 1'b1;
            r_state <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (!w_req_own) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_sw_en <= w_owner_oh;
            r_cnt   <= CW'(SETTLECYC - 1);
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SETTLE: begin
          // Aborting here keeps ptr so the same requester is favoured next time.
          if (!w_req_own) begin
            r_sw_en <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_gnt   <= w_owner_oh;
            r_cnt   <= CW'(TIMEOUT - 1);
            r_state <= S_OWN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_OWN: begin
          if (!w_req_own) begin
            r_sw_en <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_state <= S_IDLE;
          end
`ifdef LA_IOANALOG_ARB_TIMEOUT_EN
          else if (r_cnt == '0) begin
            r_sw_en <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_err   <= 1'b1;
            r_mask  <= (r_mask & req) | w_owner_oh;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
`endif
        end
        default: begin
          r_sw_en <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sw_en = r_sw_en;
  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule
